layer7_weight_loader: RTL and testbench

LAYER7_WEIGHT_LOADER -- requirements
Module: layer7_weight_loader

---
 rtl/layer7_weight_loader_if.sv | 31 +++
 rtl/layer7_weight_loader.sv | 151 +++++++++++++++
 tb/tb_layer7_weight_loader.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer7_weight_loader_if.sv
// Stream-in / weight-write bundle for the layer-7 weight loader.
// The loader sits in the slave seat: it consumes the 32-bit packed word stream
// and drives the single-port write strobe into the layer-7 weight memory.
interface layer7_weight_loader_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        write_weight_signal;
    logic [15:0] write_weight_data;
    logic [15:0] write_weight_addr;

    // Loader side.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output write_weight_signal,
        output write_weight_data,
        output write_weight_addr
    );

    // Environment side: word source plus weight-memory observer.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  write_weight_signal,
        input  write_weight_data,
        input  write_weight_addr
    );
endinterface

// File: rtl/layer7_weight_loader.sv
// Layer-7 weight loader.
// Accepts 32-bit words holding two 16-bit weights (low half first) and emits
// one write strobe per weight with a strictly ascending address 0..WEIGHT_NUM-1.
// Every output is a flop, so the memory side never sees a combinational path
// from the upstream stream. An odd WEIGHT_NUM drops the upper half of the last word.
module layer7_weight_loader #(
    parameter int WEIGHT_NUM = 400
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    layer7_weight_loader_if.slave  bus,
    output logic                   busy,
    output logic                   load_done
);

    localparam logic [15:0] LAST_IDX = 16'(WEIGHT_NUM - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WR_LO = 3'd2,
        WR_HI = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state_q,     state_d;
    logic [15:0] cnt_q,       cnt_d;
    logic [31:0] hold_q,      hold_d;
    logic        in_ready_q,  in_ready_d;
    logic        wr_sig_q,    wr_sig_d;
    logic [15:0] wr_data_q,   wr_data_d;
    logic [15:0] wr_addr_q,   wr_addr_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;

    // Next-state and next-output logic; outputs are computed for the state being
    // entered so they line up with that state once registered.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        in_ready_d = 1'b0;
        wr_sig_d   = 1'b0;
        wr_data_d  = 16'd0;
        wr_addr_d  = 16'd0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        if (abort) begin
            // Abort beats start and the FETCH handshake; all outputs fall to 0.
            state_d = IDLE;
            cnt_d   = 16'd0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d    = FETCH;
                        cnt_d      = 16'd0;
                        in_ready_d = 1'b1;
                        busy_d     = 1'b1;
                    end else begin
                        done_d = (state_q == DONE);
                    end
                end
                FETCH: begin
                    busy_d = 1'b1;
                    if (bus.in_valid) begin
                        hold_d    = bus.in_data;
                        state_d   = WR_LO;
                        wr_sig_d  = 1'b1;
                        wr_data_d = bus.in_data[15:0];
                        wr_addr_d = cnt_q;
                    end else begin
                        // Stall indefinitely until upstream offers a word.
                        in_ready_d = 1'b1;
                    end
                end
                WR_LO: begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == LAST_IDX) begin
                        // Odd count: the upper weight of this word is dropped.
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = WR_HI;
                        wr_sig_d  = 1'b1;
                        wr_data_d = hold_q[31:16];
                        wr_addr_d = cnt_q + 16'd1;
                        busy_d    = 1'b1;
                    end
                end
                WR_HI: begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = FETCH;
                        in_ready_d = 1'b1;
                        busy_d     = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end
            endcase
        end
    end

    // State, counter, hold word and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the hold word is a single register, not a memory array, so it
            // is cleared with everything else and never leaks stale data.
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            hold_q     <= 32'd0;
            in_ready_q <= 1'b0;
            wr_sig_q   <= 1'b0;
            wr_data_q  <= 16'd0;
            wr_addr_q  <= 16'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            in_ready_q <= in_ready_d;
            wr_sig_q   <= wr_sig_d;
            wr_data_q  <= wr_data_d;
            wr_addr_q  <= wr_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.in_ready            = in_ready_q;
    assign bus.write_weight_signal = wr_sig_q;
    assign bus.write_weight_data   = wr_data_q;
    assign bus.write_weight_addr   = wr_addr_q;
    assign busy                    = busy_q;
    assign load_done               = done_q;

endmodule

// File: tb/tb_layer7_weight_loader.sv
// Testbench for layer7_weight_loader: a 400-weight instance for the main job
// scenarios and a 5-weight instance for the odd-count case. Expected writes are
// queued as words are handed over and popped as strobes appear.
module tb_layer7_weight_loader;

    localparam int N_BIG   = 400;
    localparam int N_SMALL = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, abort = 1'b0, busy, load_done;
    logic start5 = 1'b0, abort5 = 1'b0, busy5, load_done5;

    layer7_weight_loader_if bus ();
    layer7_weight_loader_if bus5 ();

    layer7_weight_loader #(.WEIGHT_NUM(N_BIG)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .bus(bus), .busy(busy), .load_done(load_done)
    );

    layer7_weight_loader #(.WEIGHT_NUM(N_SMALL)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .abort(abort5),
        .bus(bus5), .busy(busy5), .load_done(load_done5)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t sb[$];
    wr_t sb5[$];
    int  tests = 0;
    int  fails = 0;
    int  strobes = 0;
    int  strobes5 = 0;

    // Strobe scoreboard and output-shape checks for the 400-weight instance.
    always @(negedge clk) begin
        wr_t e;
        if (bus.write_weight_signal === 1'b1) begin
            strobes++;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe: addr %0d data %0d with no handshake", bus.write_weight_addr, bus.write_weight_data);
            end else begin
                e = sb.pop_front();
                if (bus.write_weight_addr !== e.addr || bus.write_weight_data !== e.data) begin
                    fails++;
                    $display("FAIL strobe: got addr %0d data %0d expected addr %0d data %0d", bus.write_weight_addr, bus.write_weight_data, e.addr, e.data);
                end
            end
        end else begin
            tests++;
            if (bus.write_weight_data !== 16'd0 || bus.write_weight_addr !== 16'd0) begin
                fails++;
                $display("FAIL idle_bus: got addr %0d data %0d expected 0 0", bus.write_weight_addr, bus.write_weight_data);
            end
        end
        if (bus.in_ready === 1'b1) begin
            tests++;
            if (bus.write_weight_signal !== 1'b0 || busy !== 1'b1 || load_done !== 1'b0) begin
                fails++;
                $display("FAIL ready_state: in_ready with strobe %0b busy %0b done %0b expected 0 1 0", bus.write_weight_signal, busy, load_done);
            end
        end
    end

    // Strobe scoreboard for the 5-weight instance.
    always @(negedge clk) begin
        wr_t e;
        if (bus5.write_weight_signal === 1'b1) begin
            strobes5++;
            tests++;
            if (sb5.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe5: addr %0d data %0d", bus5.write_weight_addr, bus5.write_weight_data);
            end else begin
                e = sb5.pop_front();
                if (bus5.write_weight_addr !== e.addr || bus5.write_weight_data !== e.data) begin
                    fails++;
                    $display("FAIL strobe5: got addr %0d data %0d expected addr %0d data %0d", bus5.write_weight_addr, bus5.write_weight_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        tests++;
        if (busy !== 1'b0 || load_done !== 1'b0 || bus.in_ready !== 1'b0 ||
            bus.write_weight_signal !== 1'b0 || bus.write_weight_data !== 16'd0 ||
            bus.write_weight_addr !== 16'd0) begin
            fails++;
            $display("FAIL %s: got busy %0b done %0b rdy %0b sig %0b data %0d addr %0d expected all 0",
                     name, busy, load_done, bus.in_ready, bus.write_weight_signal,
                     bus.write_weight_data, bus.write_weight_addr);
        end
    endtask

    // One job on the 400-weight instance. abort_at / rst_at >= 0 cut the job
    // short on the strobe carrying that address.
    task automatic run_job(input string name, input bit rand_valid, input bit ign_start,
                           input int abort_at, input int rst_at);
        int  k = 0;
        int  t0;
        bit  finished = 1'b0;
        bit  v;
        strobes = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        tests++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b1 || load_done !== 1'b0) begin
            fails++;
            $display("FAIL %s_start: got busy %0b rdy %0b done %0b expected 1 1 0", name, busy, bus.in_ready, load_done);
        end
        for (int i = 0; i < 5000 && !finished; i++) begin
            if (load_done === 1'b1) begin
                finished = 1'b1;
                tests++;
                if (strobes != N_BIG) begin
                    fails++;
                    $display("FAIL %s_count: got %0d strobes expected %0d", name, strobes, N_BIG);
                end
                tests++;
                if (sb.size() != 0) begin
                    fails++;
                    $display("FAIL %s_missing: got %0d unwritten weights expected 0", name, sb.size());
                end
                if (!rand_valid) begin
                    tests++;
                    if (cyc - t0 != 600) begin
                        fails++;
                        $display("FAIL %s_latency: got %0d cycles expected 600", name, cyc - t0);
                    end
                end
            end else if (abort_at >= 0 && bus.write_weight_signal === 1'b1 &&
                         bus.write_weight_addr == 16'(abort_at)) begin
                abort = 1'b1;
                bus.in_valid = 1'b0;
                @(negedge clk);
                abort = 1'b0;
                check_all_zero({name, "_after_abort"});
                tests++;
                if (sb.size() != 0) begin
                    fails++;
                    $display("FAIL %s_pending: got %0d queued writes expected 0", name, sb.size());
                end
                repeat (6) @(negedge clk);
                tests++;
                if (strobes != abort_at + 1) begin
                    fails++;
                    $display("FAIL %s_strobes: got %0d expected %0d", name, strobes, abort_at + 1);
                end
                finished = 1'b1;
            end else if (rst_at >= 0 && bus.write_weight_signal === 1'b1 &&
                         bus.write_weight_addr == 16'(rst_at)) begin
                #2 rst = 1'b0;
                #1 check_all_zero({name, "_async"});
                sb.delete();
                bus.in_valid = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b1;
                repeat (3) @(negedge clk);
                check_all_zero({name, "_released"});
                tests++;
                if (strobes != rst_at + 1) begin
                    fails++;
                    $display("FAIL %s_strobes: got %0d expected %0d", name, strobes, rst_at + 1);
                end
                finished = 1'b1;
            end else begin
                v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                start = ign_start &&
                        ((bus.in_ready === 1'b1 && k == 3) ||
                         (bus.write_weight_signal === 1'b1 && bus.write_weight_addr == 16'd10));
                bus.in_valid = v;
                bus.in_data  = {16'(2 * k + 1), 16'(2 * k)};
                if (v && bus.in_ready === 1'b1) begin
                    sb.push_back('{addr: 16'(2 * k), data: 16'(2 * k)});
                    if (2 * k + 1 < N_BIG) sb.push_back('{addr: 16'(2 * k + 1), data: 16'(2 * k + 1)});
                    k++;
                end
                @(negedge clk);
            end
        end
        if (!finished) begin
            fails++;
            $display("FAIL %s_timeout: load_done never rose within 5000 cycles", name);
        end
        start = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3 check_all_zero("reset_async");
        tests++;
        if (busy5 !== 1'b0 || load_done5 !== 1'b0 || bus5.in_ready !== 1'b0 || bus5.write_weight_signal !== 1'b0) begin
            fails++;
            $display("FAIL reset_small: got busy %0b done %0b rdy %0b sig %0b expected 0", busy5, load_done5, bus5.in_ready, bus5.write_weight_signal);
        end
        repeat (2) @(negedge clk);
        check_all_zero("reset_held");
        // Start raised together with reset release must be taken on the first edge.
        start5 = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        tests++;
        if (busy5 !== 1'b1 || bus5.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL first_start: got busy %0b rdy %0b expected 1 1", busy5, bus5.in_ready);
        end
        abort5 = 1'b1;
        @(negedge clk);
        abort5 = 1'b0;
        tests++;
        if (busy5 !== 1'b0 || bus5.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL small_abort: got busy %0b rdy %0b expected 0 0", busy5, bus5.in_ready);
        end
    endtask

    task automatic test_odd_count();
        int k = 0;
        bit seen_last = 1'b0;
        strobes5 = 0;
        @(negedge clk);
        start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        for (int i = 0; i < 100 && !seen_last; i++) begin
            if (bus5.write_weight_signal === 1'b1 && bus5.write_weight_addr == 16'd4) begin
                seen_last = 1'b1;
                @(negedge clk);
                tests++;
                if (load_done5 !== 1'b1 || busy5 !== 1'b0 || bus5.write_weight_signal !== 1'b0) begin
                    fails++;
                    $display("FAIL odd_done: got done %0b busy %0b sig %0b expected 1 0 0", load_done5, busy5, bus5.write_weight_signal);
                end
            end else begin
                bus5.in_valid = 1'b1;
                bus5.in_data  = {16'(2 * k + 1), 16'(2 * k)};
                if (bus5.in_ready === 1'b1) begin
                    sb5.push_back('{addr: 16'(2 * k), data: 16'(2 * k)});
                    if (2 * k + 1 < N_SMALL) sb5.push_back('{addr: 16'(2 * k + 1), data: 16'(2 * k + 1)});
                    k++;
                end
                @(negedge clk);
            end
        end
        bus5.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if (!seen_last || strobes5 != N_SMALL || sb5.size() != 0 || k != 3) begin
            fails++;
            $display("FAIL odd_count: got %0d strobes %0d words %0d pending expected 5 3 0", strobes5, k, sb5.size());
        end
    endtask

    task automatic test_full_job();
        run_job("full_job", 1'b0, 1'b0, -1, -1);
    endtask

    task automatic test_backpressure();
        run_job("backpressure", 1'b1, 1'b0, -1, -1);
    endtask

    task automatic test_ignored_start();
        run_job("ignored_start", 1'b0, 1'b1, -1, -1);
        run_job("restart_from_done", 1'b0, 1'b0, -1, -1);
    endtask

    task automatic test_abort();
        run_job("abort", 1'b0, 1'b0, 37, -1);
        run_job("after_abort", 1'b0, 1'b0, -1, -1);
    endtask

    task automatic test_async_reset();
        run_job("async_rst", 1'b1, 1'b0, -1, 21);
        run_job("after_rst", 1'b0, 1'b0, -1, -1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus5.in_valid = 1'b0;
        bus5.in_data  = 32'd0;
        test_reset();
        test_odd_count();
        test_full_job();
        test_backpressure();
        test_ignored_start();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
